// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetcher with a DEPTH-entry {instr, pc} queue and redirect flush
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     instr_ready,
  output logic                     instr_valid,
  output logic [31:0]              InstrF,
  output logic [31:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic            push, pop, issue;

  // next-state logic; redirect outranks push and pop, and a stale ack in SQUASH is dropped
  always_comb begin
    push       = state_q == WAIT && imem_ack && !redirect;
    pop        = count_q != '0 && instr_ready && !redirect;
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    issue      = start && count_d < CW'(DEPTH) && !redirect;
    fetch_pc_d = redirect ? {redirect_pc[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rd_d       = redirect ? '0 : rd_q + PW'(pop);
    wr_d       = redirect ? '0 : wr_q + PW'(push);
    state_d    = state_q == IDLE ? (issue ? WAIT : IDLE)
               : imem_ack        ? (issue ? WAIT : IDLE)
               : state_q == WAIT ? (redirect ? SQUASH : WAIT)
               :                   SQUASH;
    req_d      = state_d != IDLE;
    addr_d     = (req_q && !imem_ack) ? addr_q : fetch_pc_d;
  end

  // control state, pointers and the registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end

  // queue storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= imem_rdata;
      pc_q[wr_q]   <= fetch_pc_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign count       = count_q;
  assign instr_valid = count_q != '0;
  assign InstrF      = instr_valid ? data_q[rd_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_q[rd_q] : 32'h0;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: table-driven and directed checks of the prefetch queue against a wait-state memory model
module tb_instr_prefetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] InstrF;
  logic [31:0] instr_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int waits  = 0;
  int wcnt   = 0;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .InstrF(InstrF), .instr_pc(instr_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // memory model: acks after `waits` extra cycles of req
  assign imem_ack   = imem_req && (wcnt == waits);
  assign imem_rdata = word_at(imem_addr);

  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (!reset && imem_req && imem_ack && count == 3'd4 && !redirect) begin
      errors = errors + 1;
      $display("FAIL overflow: push with count=%0d required below 4", count);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic st, input logic rdy, input int w);
    @(negedge clk);
    reset = 1'b1; start = st; instr_ready = rdy; redirect = 1'b0; waits = w;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        rst, st, rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [2:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic st, logic rdy, logic req, logic [31:0] addr,
                              logic val, logic [31:0] pc, logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.rdy = rdy; v.ereq = req; v.eaddr = addr;
    v.evalid = val; v.epc = pc; v.ecnt = cnt;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // fill to DEPTH with ready low, then drain and stream
    tbl.push_back(mk(1, 1, 0, 0, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h04, 1, 32'h00, 1));
    tbl.push_back(mk(0, 1, 0, 1, 32'h08, 1, 32'h00, 2));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0C, 1, 32'h00, 3));
    tbl.push_back(mk(0, 1, 0, 0, 32'h10, 1, 32'h00, 4));
    tbl.push_back(mk(0, 1, 1, 0, 32'h10, 1, 32'h00, 4));
    tbl.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h04, 3));
    tbl.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'h08, 3));
    tbl.push_back(mk(0, 1, 1, 1, 32'h18, 1, 32'h0C, 3));
    tbl.push_back(mk(0, 1, 1, 1, 32'h1C, 1, 32'h10, 3));
    tbl.push_back(mk(0, 1, 1, 1, 32'h20, 1, 32'h14, 3));
    // fresh reset, ready high: one instruction per cycle
    tbl.push_back(mk(1, 1, 1, 0, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'h04, 1, 32'h00, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'h08, 1, 32'h04, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'h0C, 1, 32'h08, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h0C, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; start = tbl[i].st; instr_ready = tbl[i].rdy; redirect = 1'b0;
      #1;
      chk($sformatf("row%0d req", i), imem_req, tbl[i].ereq);
      chk($sformatf("row%0d addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("row%0d valid", i), instr_valid, tbl[i].evalid);
      chk($sformatf("row%0d pc", i), instr_pc, tbl[i].epc);
      chk($sformatf("row%0d instr", i), InstrF, tbl[i].evalid ? word_at(tbl[i].epc) : 32'h0);
      chk($sformatf("row%0d count", i), count, tbl[i].ecnt);
    end

    // redirect during a 3-wait-state fetch: stale word dropped, address held until its ack
    do_reset(1, 1, 3);
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    #1;
    chk("squash req", imem_req, 1);
    chk("squash addr held", imem_addr, 32'h0);
    chk("squash count", count, 0);
    tick();
    #1;
    chk("stale ack", imem_ack, 1);
    chk("stale addr", imem_addr, 32'h0);
    tick();
    #1;
    chk("new addr", imem_addr, 32'h100);
    chk("new req", imem_req, 1);
    chk("stale dropped", instr_valid, 0);
    for (int i = 0; i < 20 && !instr_valid; i++) begin tick(); #1; end
    chk("redir valid", instr_valid, 1);
    chk("redir pc", instr_pc, 32'h100);
    chk("redir instr", InstrF, word_at(32'h100));

    // redirect with simultaneous push and pop at count 2
    do_reset(1, 0, 0);
    tick();
    tick();
    tick();
    #1;
    chk("pre count", count, 2);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    #1;
    chk("flush count", count, 0);
    chk("flush valid", instr_valid, 0);
    chk("flush instr", InstrF, 32'h0);
    chk("flush pc", instr_pc, 32'h0);
    chk("flush req", imem_req, 0);
    chk("flush addr", imem_addr, 32'h200);
    tick();
    tick();
    #1;
    chk("after flush pc", instr_pc, 32'h200);
    chk("after flush valid", instr_valid, 1);

    // wrap of fetch_pc, masked redirect_pc, start low stops issue
    do_reset(1, 1, 0);
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    tick();
    redirect = 1'b0;
    #1;
    chk("wrap addr", imem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 10 && !instr_valid; i++) begin tick(); #1; end
    chk("wrap pc0", instr_pc, 32'hFFFF_FFF8);
    tick();
    #1;
    chk("wrap pc1", instr_pc, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("wrap pc2", instr_pc, 32'h0);
    start = 1'b0;
    tick();
    #1;
    chk("stop req", imem_req, 0);
    chk("stop pc", instr_pc, 32'h4);
    tick();
    #1;
    chk("stop req2", imem_req, 0);
    chk("stop empty", instr_valid, 0);

    // asynchronous reset mid-transaction
    do_reset(1, 0, 0);
    tick(); tick(); tick(); tick();
    #1;
    chk("pre rst count", count, 3);
    chk("pre rst req", imem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst req", imem_req, 0);
    chk("arst addr", imem_addr, 32'h0);
    chk("arst valid", instr_valid, 0);
    chk("arst instr", InstrF, 32'h0);
    chk("arst pc", instr_pc, 32'h0);
    chk("arst count", count, 0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
